// File: rtl/tinker_pkg.sv
// rtl/tinker_pkg.sv - shared Tinker core defaults, types and helpers
package tinker_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_AW = 5;
  localparam logic [DEF_DATA_W-1:0] DEF_SP_RESET = 64'd524288;

  typedef logic [DEF_REG_AW-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_LD, OP_ST, OP_BR, OP_HALT
  } opcode_t;

  function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/tinker_scoreboard.sv
// rtl/tinker_scoreboard.sv - per-register pending bits with claim, clear and flush
// Writes clear before claims set, so a same-cycle claim marks the new producer.
module tinker_scoreboard
  import tinker_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int AW       = 5
)(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_WR-1:0]    i_wr_act,
  input  logic [NUM_WR*AW-1:0] i_wr_addr,
  input  logic                 i_claim_en,
  input  logic [AW-1:0]        i_claim_addr,
  input  logic                 i_flush,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  input  logic [NUM_RD-1:0]    i_rd_mask,
  output logic                 o_claim_ok,
  output logic [NUM_RD-1:0]    o_rd_pending
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_clear;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_set;

  always_comb begin
    w_clear = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (i_wr_act[p]) w_clear[i_wr_addr[p*AW +: AW]] = 1'b1;
  end

  assign w_eff = r_pending & ~w_clear;

  always_comb begin
    o_claim_ok = i_claim_en && idx_in_range(32'(i_claim_addr), NUM_REGS)
                 && !w_eff[i_claim_addr];
    w_set = '0;
    if (o_claim_ok) w_set[i_claim_addr] = 1'b1;
  end

  always_comb begin
    o_rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++)
      o_rd_pending[i] = idx_in_range(32'(i_rd_addr[i*AW +: AW]), NUM_REGS)
                        && r_pending[i_rd_addr[i*AW +: AW]] && !i_rd_mask[i];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     r_pending <= '0;
    else if (i_flush) r_pending <= '0;
    else              r_pending <= w_eff | w_set;
  end

endmodule

// File: rtl/tinker_regfile_sb.sv
// rtl/tinker_regfile_sb.sv - multi-port register file with write bypass and RAW scoreboard
// Later write ports override earlier ones both in the array and on the bypass path.
module tinker_regfile_sb
  import tinker_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int SP_IDX   = 31,
  parameter logic [DATA_W-1:0] SP_RESET = DEF_SP_RESET,
  parameter int BYPASS   = 1,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_pending,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*AW-1:0]     i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic                     i_claim_en,
  input  logic [AW-1:0]            i_claim_addr,
  output logic                     o_claim_ok,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_stack_ptr,
  output logic                     o_wr_conflict
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              r_wr_conflict;
  logic [NUM_WR-1:0] w_wr_act;
  logic [NUM_RD-1:0] w_rd_byp;
  logic              w_conflict;

  always_comb begin
    w_wr_act = '0;
    for (int p = 0; p < NUM_WR; p++)
      w_wr_act[p] = i_wr_en[p] && idx_in_range(32'(i_wr_addr[p*AW +: AW]), NUM_REGS);
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (w_wr_act[p] && w_wr_act[q] && (i_wr_addr[p*AW +: AW] == i_wr_addr[q*AW +: AW]))
          w_conflict = 1'b1;
  end

  always_comb begin
    o_rd_data = '0;
    w_rd_byp  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (idx_in_range(32'(i_rd_addr[i*AW +: AW]), NUM_REGS))
        o_rd_data[i*DATA_W +: DATA_W] = r_mem[i_rd_addr[i*AW +: AW]];
      if (BYPASS != 0)
        for (int p = 0; p < NUM_WR; p++)
          if (w_wr_act[p] && (i_wr_addr[p*AW +: AW] == i_rd_addr[i*AW +: AW])) begin
            o_rd_data[i*DATA_W +: DATA_W] = i_wr_data[p*DATA_W +: DATA_W];
            w_rd_byp[i] = 1'b1;
          end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_mem[r] <= (r == SP_IDX) ? SP_RESET : '0;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (w_wr_act[p]) r_mem[i_wr_addr[p*AW +: AW]] <= i_wr_data[p*DATA_W +: DATA_W];
      r_wr_conflict <= w_conflict;
    end
  end

  assign o_stack_ptr   = r_mem[SP_IDX];
  assign o_wr_conflict = r_wr_conflict;

  tinker_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_sb (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr_act     (w_wr_act),
    .i_wr_addr    (i_wr_addr),
    .i_claim_en   (i_claim_en),
    .i_claim_addr (i_claim_addr),
    .i_flush      (i_flush),
    .i_rd_addr    (i_rd_addr),
    .i_rd_mask    (w_rd_byp),
    .o_claim_ok   (o_claim_ok),
    .o_rd_pending (o_rd_pending)
  );

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// tb/tb_tinker_regfile_sb.sv - self-checking bench for tinker_regfile_sb (bypass and no-bypass builds)
module tb_tinker_regfile_sb;
  import tinker_pkg::*;

  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam logic [63:0] SPR = 64'd524288;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rdp_b, rdp_n;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             claim_en, flush;
  logic [AW-1:0]    claim_addr;
  logic             cok_b, cok_n, conf_b, conf_n;
  logic [DW-1:0]    sp_b, sp_n;

  int n_checks = 0;
  int n_fail = 0;

  word_t m_reg [32];
  bit    m_pend [32];
  bit    m_conf;

  always #5 clk = ~clk;

  tinker_regfile_sb dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
    .o_rd_pending(rdp_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_claim_en(claim_en), .i_claim_addr(claim_addr), .o_claim_ok(cok_b),
    .i_flush(flush), .o_stack_ptr(sp_b), .o_wr_conflict(conf_b));

  tinker_regfile_sb #(.BYPASS(0)) dut_n (
    .i_clk(clk), .i_reset(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n),
    .o_rd_pending(rdp_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_claim_en(claim_en), .i_claim_addr(claim_addr), .o_claim_ok(cok_n),
    .i_flush(flush), .o_stack_ptr(sp_n), .o_wr_conflict(conf_n));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] wa(input int p);
    return wr_addr[p*AW +: AW];
  endfunction

  function automatic bit written(input logic [4:0] a);
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && wa(p) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic word_t exp_rd(input int i, input bit byp);
    logic [4:0] a;
    word_t v;
    a = rd_addr[i*AW +: AW];
    v = m_reg[a];
    if (byp)
      for (int p = 0; p < NW; p++)
        if (wr_en[p] && wa(p) == a) v = wr_data[p*DW +: DW];
    return v;
  endfunction

  function automatic bit exp_pend(input int i, input bit byp);
    logic [4:0] a;
    a = rd_addr[i*AW +: AW];
    return m_pend[a] && !(byp && written(a));
  endfunction

  function automatic bit exp_cok();
    return claim_en && !(m_pend[claim_addr] && !written(claim_addr));
  endfunction

  // Reference model: architectural state advanced from the rules, not the RTL.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r]  <= (r == 31) ? SPR : 64'd0;
        m_pend[r] <= 1'b0;
      end
      m_conf <= 1'b0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (wr_en[p]) m_reg[wa(p)] <= wr_data[p*DW +: DW];
      m_conf <= (wr_en == 2'b11) && (wa(0) == wa(1));
      for (int r = 0; r < 32; r++)
        m_pend[r] <= flush ? 1'b0 :
                     (exp_cok() && 5'(r) == claim_addr) ? 1'b1 :
                     written(5'(r)) ? 1'b0 : m_pend[r];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rd_data_byp[%0d]", i), rd_data_b[i*DW +: DW], exp_rd(i, 1'b1));
      chk($sformatf("rd_data_nobyp[%0d]", i), rd_data_n[i*DW +: DW], exp_rd(i, 1'b0));
      chk($sformatf("rd_pending_byp[%0d]", i), 64'(rdp_b[i]), 64'(exp_pend(i, 1'b1)));
      chk($sformatf("rd_pending_nobyp[%0d]", i), 64'(rdp_n[i]), 64'(exp_pend(i, 1'b0)));
    end
    chk("claim_ok_byp", 64'(cok_b), 64'(exp_cok()));
    chk("claim_ok_nobyp", 64'(cok_n), 64'(exp_cok()));
    chk("stack_ptr_byp", sp_b, m_reg[31]);
    chk("stack_ptr_nobyp", sp_n, m_reg[31]);
    chk("wr_conflict_byp", 64'(conf_b), 64'(m_conf));
    chk("wr_conflict_nobyp", 64'(conf_n), 64'(m_conf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [4:0] a0; logic [63:0] d0; logic [4:0] a1; logic [63:0] d1; } wvec_t;
  wvec_t vecs [4];

  initial begin
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    vecs[0] = '{5'd10, 64'hA0, 5'd11, 64'hB1};
    vecs[1] = '{5'd0, 64'h5, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{5'd11, 64'h1111, 5'd10, 64'h2222};
    vecs[3] = '{5'd30, 64'h8000_0000_0000_0000, 5'd29, 64'h7};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset stack_ptr", sp_b, SPR);
    chk("reset wr_conflict", 64'(conf_b), 64'd0);
    for (int r = 0; r < 31; r++) begin
      rd_addr = {5'(r), 5'(r), 5'(r)};
      #1;
      for (int i = 0; i < NR; i++) begin
        chk($sformatf("reset r%0d data", r), rd_data_b[i*DW +: DW], 64'd0);
        chk($sformatf("reset r%0d pending", r), 64'(rdp_b[i]), 64'd0);
      end
    end

    // write then read, bypass vs no bypass
    step();
    rd_addr = {5'd0, 5'd0, 5'd5};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'd0, 64'hDEAD_BEEF};
    @(negedge clk);
    chk("bypass same-cycle r5", rd_data_b[63:0], 64'hDEAD_BEEF);
    chk("no-bypass same-cycle r5", rd_data_n[63:0], 64'd0);
    step();
    wr_en = '0;
    @(negedge clk);
    chk("array r5 byp", rd_data_b[63:0], 64'hDEAD_BEEF);
    chk("array r5 nobyp", rd_data_n[63:0], 64'hDEAD_BEEF);

    // dual-write conflict
    step();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {64'h22, 64'h11};
    rd_addr = {5'd0, 5'd0, 5'd7};
    step();
    wr_en = '0;
    @(negedge clk);
    chk("conflict r7 winner", rd_data_b[63:0], 64'h22);
    chk("conflict pulse", 64'(conf_b), 64'd1);
    step();
    @(negedge clk);
    chk("conflict pulse ends", 64'(conf_b), 64'd0);

    // claim / stall
    step();
    claim_en = 1'b1; claim_addr = 5'd3; rd_addr = {5'd0, 5'd0, 5'd3};
    @(negedge clk);
    chk("claim r3 ok", 64'(cok_b), 64'd1);
    step();
    @(negedge clk);
    chk("reclaim r3 refused", 64'(cok_b), 64'd0);
    chk("r3 pending", 64'(rdp_b[0]), 64'd1);
    step();
    wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {64'h33, 64'h0};
    @(negedge clk);
    chk("claim with write ok", 64'(cok_b), 64'd1);
    chk("pending masked by bypass", 64'(rdp_b[0]), 64'd0);
    chk("pending visible no bypass", 64'(rdp_n[0]), 64'd1);
    step();
    wr_en = '0; claim_en = 1'b0;
    @(negedge clk);
    chk("new producer pending", 64'(rdp_b[0]), 64'd1);
    chk("r3 written", rd_data_b[63:0], 64'h33);
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {64'd0, 64'h44};
    step();
    wr_en = '0;
    @(negedge clk);
    chk("write clears pending", 64'(rdp_b[0]), 64'd0);

    // flush overrides claim
    for (int k = 0; k < 3; k++) begin
      step();
      claim_en = 1'b1;
      claim_addr = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
    end
    step();
    claim_addr = 5'd9; flush = 1'b1;
    @(negedge clk);
    chk("claim_ok during flush", 64'(cok_b), 64'd1);
    step();
    claim_en = 1'b0; flush = 1'b0; rd_addr = {5'd4, 5'd2, 5'd1};
    @(negedge clk);
    chk("flush clears r1/r2/r4", 64'(rdp_b), 64'd0);
    rd_addr = {5'd0, 5'd0, 5'd9};
    #1;
    chk("flush beats claim r9", 64'(rdp_b[0]), 64'd0);

    // directed dual-port writes with bypassed reads
    foreach (vecs[v]) begin
      step();
      wr_en = 2'b11;
      wr_addr = {vecs[v].a1, vecs[v].a0};
      wr_data = {vecs[v].d1, vecs[v].d0};
      rd_addr = {vecs[v].a1, vecs[v].a0, 5'd10};
    end
    step();
    wr_en = '0;
    rd_addr = {5'd12, 5'd11, 5'd10};
    @(negedge clk);
    chk("vec r10", rd_data_b[63:0], 64'h2222);
    chk("vec r11", rd_data_b[127:64], 64'h1111);
    chk("vec r12", rd_data_b[191:128], 64'hFFFF_FFFF_FFFF_FFFF);

    // async reset mid-operation
    step();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd31}; wr_data = {64'd0, 64'hABC};
    step();
    wr_en = '0;
    @(negedge clk);
    chk("sp written", sp_b, 64'hABC);
    step();
    wr_en = 2'b01; wr_data = {64'd0, 64'h1234};
    #2 rst_n = 1'b0;
    #1;
    chk("async reset sp byp", sp_b, SPR);
    chk("async reset sp nobyp", sp_n, SPR);
    wr_en = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("sp after release", sp_b, SPR);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tinker_regfile_sb.md
Name: tinker_regfile_sb

Overview:
- Parametrised, scoreboarded register file for the next-generation Tinker core.
- Replaces the single-write, flag-driven register array with:
  - NUM_RD combinational read ports and NUM_WR synchronous write ports (ALU and load return).
  - Optional write-to-read bypass.
  - A per-register pending scoreboard, so the decoder can issue instructions back-to-back and stall only on true RAW hazards.
- Sits between the instruction decoder (read addresses, claims) and the ALU/memory writeback paths.

Parameters:
- DATA_W, 64: register width in bits.
- NUM_REGS, 32: number of architectural registers.
- NUM_RD, 3: read ports (rs, rt, rd-as-source).
- NUM_WR, 2: write ports; the higher index has higher priority.
- SP_IDX, 31: index of the stack-pointer register.
- SP_RESET, 524288: reset value of register SP_IDX.
- BYPASS, 1: 1 means same-cycle write data is forwarded to reads.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- rd_addr, input, NUM_RD*AW: read addresses, packed. AW = $clog2(NUM_REGS).
- rd_data, output, NUM_RD*DATA_W: read data, combinational.
- rd_pending, output, NUM_RD: 1 when the addressed register awaits a write.
- wr_en, input, NUM_WR: write enables.
- wr_addr, input, NUM_WR*AW: write addresses.
- wr_data, input, NUM_WR*DATA_W: write data.
- claim_en, input, 1: decoder reserves claim_addr as the destination of an issued instruction.
- claim_addr, input, AW: register being claimed.
- claim_ok, output, 1: claim is accepted this cycle (combinational).
- flush, input, 1: clear all pending bits (halt or redirect).
- stack_ptr, output, DATA_W: current value of register SP_IDX.
- wr_conflict, output, 1: registered one-cycle pulse indicating two write ports hit the same register last cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers are 0 except SP_IDX, which is SP_RESET.
  - All pending bits are 0 and wr_conflict is 0.
  - stack_ptr therefore shows SP_RESET immediately.
  - Release is synchronous to clk. Reset mid-operation discards any in-flight write that has not reached an edge.
- Writes:
  - On a rising edge, every port with wr_en=1 writes its wr_data to its wr_addr.
  - If several enabled ports share an address, the highest-index port wins, and wr_conflict=1 on the next cycle only.
  - Write latency is 1 cycle; the written value is visible in the array after the edge.
- Reads:
  - rd_data[i] = array[rd_addr[i]], combinational.
  - If BYPASS=1 and some enabled write port matches rd_addr[i], rd_data[i] is that port's wr_data, using the highest-index match.
  - If BYPASS=0, the old array value is returned until the edge.
- Scoreboard: pending[NUM_REGS], one bit per register.
  - claim_ok = claim_en & addr_valid & ~pending_eff[claim_addr].
  - pending_eff is pending with bits cleared for registers being written this cycle.
  - On the edge: any enabled write clears pending[wr_addr]. Then, if claim_ok, pending[claim_addr] is set. A claim and a write to the same register in the same cycle therefore leaves pending=1, because the new producer wins.
  - A claim with claim_ok=0 has no effect; the decoder holds claim_en and retries.
  - Writing a register that is not pending is legal and leaves its pending bit unchanged.
  - rd_pending[i] = pending[rd_addr[i]], masked to 0 when BYPASS=1 and a matching write is present this cycle.
- flush=1: all pending bits are 0 after the edge. Flush overrides a same-cycle claim. Writes in that cycle still update the array.
- Out-of-range addresses (only possible when NUM_REGS is not a power of two):
  - Reads return 0 with rd_pending=0.
  - Writes are ignored.
  - claim_ok=0.
- stack_ptr is the array value of SP_IDX, after the edge, with no bypass.
- Width rules:
  - All data is DATA_W wide, with no sign handling.
  - AW = $clog2(NUM_REGS), minimum 1.

Decomposition:
- tinker_pkg holds:
  - the DATA_W and REG_AW defaults and the SP_RESET constant;
  - a typedef reg_idx_t (logic [REG_AW-1:0]) and a typedef word_t (logic [DATA_W-1:0]).
  - The core's opcode enum moves here too, so the decoder and ALU share it.
- One sub-module, tinker_scoreboard:
  - holds the pending-bit vector;
  - contains the claim, clear and flush logic;
  - provides the claim_ok and rd_pending lookups.
- The array, write-priority logic and bypass stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release. Expect stack_ptr=524288, reads of r0..r30 return 0, rd_pending=0, wr_conflict=0.
- Write then read: wr_en[0]=1, addr 5, data 0xDEAD_BEEF.
  - Same cycle, BYPASS=1: rd_data for r5 = 0xDEAD_BEEF.
  - Next cycle: the array holds it.
  - With BYPASS=0, the same-cycle read returns 0.
- Dual-write conflict: both ports write r7 with data 0x11 and 0x22. Expect r7=0x22 next cycle and a single-cycle wr_conflict pulse.
- Claim/stall:
  - Claim r3: claim_ok=1, and next cycle rd_pending for r3 is 1.
  - A second claim of r3 gives claim_ok=0.
  - A port-1 write of r3 with a simultaneous claim of r3 gives claim_ok=1, and pending stays 1.
  - A write alone then clears pending.
- Flush: claim r1, r2, r4, then assert flush together with a claim of r9. All pending bits are 0 afterwards and r9 is not pending.
- Async reset mid-op: drive reset low between edges while a write to r31 is enabled. stack_ptr returns to 524288 without a clock edge, and r31 keeps SP_RESET after release.
